// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller.
package alu_bist_pkg;

    localparam int OPND_W = 4;
    localparam int OP_W   = 3;
    localparam int LFSR_W = 8;
    localparam int RESP_W = 6;

    // x^8 + x^6 + x^5 + x^4 + 1, feedback taken from bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bist_lfsr8.sv
// 8-bit Fibonacci shift register with parallel XOR input; serves as both
// operand generator (input tied to 0) and response compactor (MISR).
module bist_lfsr8
    import alu_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_TAPS,
    parameter logic [LFSR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic              en_i,
    input  logic [RESP_W-1:0] in_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RESET_VAL;
        end else if (load_i) begin
            q_q <= load_val_i;
        end else if (en_i) begin
            q_q <= {q_q[LFSR_W-2:0], ^(q_q & TAPS)} ^ {{(LFSR_W-RESP_W){1'b0}}, in_i};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller: drives LFSR-generated vectors into an external ALU and
// compacts the delayed responses into an 8-bit MISR signature.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int                NUM_VECTORS = 64,
    parameter int                ALU_LATENCY = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5,
    parameter logic [LFSR_W-1:0] GOLDEN_SIG  = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [OPND_W-1:0] a,
    output logic [OPND_W-1:0] b,
    output logic [OP_W-1:0]   op,
    input  logic [OPND_W-1:0] result,
    input  logic              carry_out,
    input  logic              zero,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LFSR_W-1:0] signature
);

    state_e                 state_q;
    logic [8:0]             cnt_q;
    logic [1:0]             drain_q;
    logic [ALU_LATENCY-1:0] tag_q;
    logic [LFSR_W-1:0]      gen_q;
    logic                   start_run;
    logic                   in_run;

    assign in_run    = (state_q == ST_RUN);
    assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    bist_lfsr8 #(.TAPS(LFSR_TAPS), .RESET_VAL(LFSR_SEED)) u_gen (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (start_run),
        .load_val_i (LFSR_SEED),
        .en_i       (in_run),
        .in_i       ('0),
        .q_o        (gen_q)
    );

    // Tags are always clear in IDLE/DONE, so load and enable never collide
    bist_lfsr8 #(.TAPS(LFSR_TAPS), .RESET_VAL(8'h00)) u_misr (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (start_run),
        .load_val_i (8'h00),
        .en_i       (tag_q[ALU_LATENCY-1]),
        .in_i       ({zero, carry_out, result}),
        .q_o        (signature)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            tag_q   <= '0;
        end else begin
            tag_q <= (tag_q << 1) | ALU_LATENCY'(in_run);
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 9'd1;
                    if (cnt_q == 9'(NUM_VECTORS - 1)) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    if (drain_q == 2'(ALU_LATENCY - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);
    assign pass = done && (signature == GOLDEN_SIG);
    assign a    = in_run ? gen_q[7:4] : '0;
    assign b    = in_run ? gen_q[3:0] : '0;
    assign op   = in_run ? cnt_q[OP_W-1:0] : '0;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench: two controllers (ALU latency 1 and 3) driving behavioural
// ALU pipelines; checks vector sequence, timing, signature and pass flag.
module tb_alu_bist_ctrl;

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [5:0] alu_f(input logic [3:0] x, input logic [3:0] y,
                                         input logic [2:0] o);
        logic [4:0] r;
        case (o)
            3'd0:    r = {1'b0, x} + {1'b0, y};
            3'd1:    r = {1'b0, x} - {1'b0, y};
            3'd2:    r = {1'b0, x & y};
            3'd3:    r = {1'b0, x | y};
            3'd4:    r = {1'b0, x ^ y};
            3'd5:    r = {x, 1'b0};
            3'd6:    r = {x[0], 1'b0, x[3:1]};
            default: r = {1'b0, ~x};
        endcase
        return {(r[3:0] == 4'd0), r[4], r[3:0]};
    endfunction

    function automatic logic [7:0] model_sig(input bit stuck);
        logic [7:0] q;
        logic [7:0] m;
        logic [5:0] rsp;
        q = 8'hA5;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rsp = alu_f(q[7:4], q[3:0], 3'(i));
            if (stuck) rsp[0] = 1'b0;
            m = lfsr_step(m) ^ {2'b00, rsp};
            q = lfsr_step(q);
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = model_sig(1'b0);
    localparam logic [7:0] GOLD_STUCK = model_sig(1'b1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stuck = 1'b0;

    logic [3:0] a1, b1, a3, b3;
    logic [2:0] op1, op3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [7:0] sig1, sig3;
    logic [5:0] r1_q;
    logic [5:0] r3_q [3];
    logic [5:0] resp1, resp3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r1_q    <= alu_f(a1, b1, op1);
        r3_q[0] <= alu_f(a3, b3, op3);
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end

    assign resp1 = stuck ? (r1_q & 6'b111110) : r1_q;
    assign resp3 = stuck ? (r3_q[2] & 6'b111110) : r3_q[2];

    alu_bist_ctrl #(.NUM_VECTORS(8), .ALU_LATENCY(1), .LFSR_SEED(8'hA5), .GOLDEN_SIG(GOLD)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a1), .b(b1), .op(op1),
        .result(resp1[3:0]), .carry_out(resp1[4]), .zero(resp1[5]),
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
    );

    alu_bist_ctrl #(.NUM_VECTORS(8), .ALU_LATENCY(3), .LFSR_SEED(8'hA5), .GOLDEN_SIG(GOLD)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a3), .b(b3), .op(op3),
        .result(resp3[3:0]), .carry_out(resp3[4]), .zero(resp3[5]),
        .busy(busy3), .done(done3), .pass(pass3), .signature(sig3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Start pulse, then cycle-by-cycle checks for cycles T+1..T+13.
    task automatic run_chk(input bit pulses, input bit hand);
        logic [7:0] q;
        logic [3:0] ha [3];
        logic [3:0] hb [3];
        ha[0] = 4'hA; ha[1] = 4'h4; ha[2] = 4'h9;
        hb[0] = 4'h5; hb[1] = 4'hA; hb[2] = 4'h5;
        q = 8'hA5;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            chk("busy1", 32'(busy1), 32'(k <= 9));
            chk("done1", 32'(done1), 32'(k >= 10));
            chk("busy3", 32'(busy3), 32'(k <= 11));
            chk("done3", 32'(done3), 32'(k >= 12));
            chk("a1", 32'(a1), (k <= 8) ? 32'(q[7:4]) : 32'd0);
            chk("b1", 32'(b1), (k <= 8) ? 32'(q[3:0]) : 32'd0);
            chk("op1", 32'(op1), (k <= 8) ? 32'(k - 1) : 32'd0);
            chk("a3", 32'(a3), (k <= 8) ? 32'(q[7:4]) : 32'd0);
            chk("op3", 32'(op3), (k <= 8) ? 32'(k - 1) : 32'd0);
            if (hand && k <= 3) begin
                chk("hand_a", 32'(a1), 32'(ha[k-1]));
                chk("hand_b", 32'(b1), 32'(hb[k-1]));
            end
            if (k <= 8) q = lfsr_step(q);
            start = pulses && (k == 4 || k == 9);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_sig", 32'(sig1), 32'd0);
        chk("rst_abop", 32'({a1, b1, op1}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy1), 32'd0);
        chk("idle_a", 32'(a1), 32'd0);

        // First run with stray start pulses in RUN and DRAIN
        run_chk(1'b1, 1'b1);
        chk("r1_sig1", 32'(sig1), 32'(GOLD));
        chk("r1_pass1", 32'(pass1), 32'd1);
        chk("r1_sig3", 32'(sig3), 32'(GOLD));
        chk("r1_pass3", 32'(pass3), 32'd1);
        repeat (3) @(negedge clk);
        chk("hold_done", 32'(done1), 32'd1);
        chk("hold_sig", 32'(sig1), 32'(GOLD));
        chk("hold_pass", 32'(pass1), 32'd1);

        // Restart from DONE
        run_chk(1'b0, 1'b0);
        chk("r2_sig1", 32'(sig1), 32'(GOLD));
        chk("r2_sig3", 32'(sig3), 32'(GOLD));

        // result[0] stuck-at-0
        stuck = 1'b1;
        run_chk(1'b0, 1'b0);
        chk("stk_sig1", 32'(sig1), 32'(GOLD_STUCK));
        chk("stk_pass1", 32'(pass1), 32'd0);
        chk("stk_pass3", 32'(pass3), 32'd0);
        stuck = 1'b0;

        // Reset mid-run
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_busy1", 32'(busy1), 32'd0);
        chk("mr_done1", 32'(done1), 32'd0);
        chk("mr_pass1", 32'(pass1), 32'd0);
        chk("mr_sig1", 32'(sig1), 32'd0);
        chk("mr_abop1", 32'({a1, b1, op1}), 32'd0);
        chk("mr_busy3", 32'(busy3), 32'd0);
        chk("mr_sig3", 32'(sig3), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("mr_idle", 32'(busy1), 32'd0);
        run_chk(1'b0, 1'b1);
        chk("mr_sig_after", 32'(sig1), 32'(GOLD));
        chk("mr_pass_after", 32'(pass1), 32'd1);
        chk("mr_pass3_after", 32'(pass3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bist_ctrl.md
ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 64, number of vectors issued per run (1..256).
REQ-002 SHALL have parameter ALU_LATENCY, default 1, clock cycles from operand drive to valid ALU response (1..4).
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, operand generator seed (nonzero).
REQ-004 SHALL have parameter GOLDEN_SIG, default 8'h00, expected final signature.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  begin a run; sampled in IDLE and DONE only.
REQ-008 SHALL have port a  output  4  ALU operand A.
REQ-009 SHALL have port b  output  4  ALU operand B.
REQ-010 SHALL have port op  output  3  ALU opcode.
REQ-011 SHALL have port result  input  4  ALU result.
REQ-012 SHALL have port carry_out  input  1  ALU carry.
REQ-013 SHALL have port zero  input  1  ALU zero flag.
REQ-014 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port pass  output  1  signature == GOLDEN_SIG; meaningful only while done=1, else 0.
REQ-017 SHALL have port signature  output  8  current MISR contents.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE/DONE + start=1 at edge T SHALL go to RUN, load generator LFSR with LFSR_SEED, clear MISR to 0, clear vector counter to 0.
REQ-020 RUN SHALL drive one vector per cycle: a=lfsr[7:4], b=lfsr[3:0], op=counter[2:0], so ops cycle 000..111 in order.
REQ-021 Generator SHALL be an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing once per issued vector.
REQ-022 Vector i SHALL be driven during cycle T+1+i, i = 0..NUM_VECTORS-1; after the last vector the FSM SHALL go to DRAIN.
REQ-023 DRAIN SHALL last exactly ALU_LATENCY cycles, then go to DONE; done first high in cycle T+1+NUM_VECTORS+ALU_LATENCY.
REQ-024 A valid-tag shift register of depth ALU_LATENCY SHALL mark which cycles carry a response to an issued vector.
REQ-025 On each tagged cycle the MISR SHALL shift by the same polynomial and XOR {zero, carry_out, result} into bits [5:0]; untagged cycles SHALL leave the MISR unchanged.
REQ-026 Exactly NUM_VECTORS responses SHALL be compacted per run.
REQ-027 In IDLE, DRAIN and DONE, a, b and op SHALL be 0.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 DONE SHALL hold done, pass and signature until the next start; start in DONE SHALL restart per REQ-019.
REQ-030 Counter SHALL be wide enough for NUM_VECTORS=256 without wrap before terminal compare.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, a=b=op=0, busy=0, done=0, pass=0, signature=0, counter=0, valid tags=0, LFSR=LFSR_SEED.
REQ-032 Reset mid-run SHALL abort the run; no partial signature retained; first start after release SHALL behave per REQ-019.

Structure
REQ-033 Package alu_bist_pkg SHALL hold the state enum, LFSR/MISR tap mask, operand/opcode widths.
REQ-034 Sub-module bist_lfsr8 (8-bit shift register, tap mask, enable, 6-bit parallel XOR input) SHALL be instantiated twice: generator (input 0) and MISR.

Verification
REQ-035 Reset: rst_n=0 mid-run -> all outputs 0 within the same cycle, FSM IDLE.
REQ-036 NUM_VECTORS=8, ALU_LATENCY=1, alu_seq attached, start pulse at T -> vector 0 a=4'hA, b=4'h5, op=000; op 000..111 in order; busy T+1..T+9; done at T+10.
REQ-037 Same run, GOLDEN_SIG set to model-computed signature -> pass=1; result[0] forced stuck-at-0 -> pass=0.
REQ-038 start pulses during RUN and DRAIN -> no restart; done timing unchanged.
REQ-039 start in DONE -> second run yields identical signature and timing.
REQ-040 ALU_LATENCY=3 with delay-matched model -> exactly 8 MISR updates, done at T+12.
